pc_fetch_unit: RTL and testbench

- Program-counter and next-PC stage directly upstream of the opcode decoder.
- Holds the PC and drives the instruction-memory address; the fetched word's opcode feeds the decoder.
- Consumes the decoder's one-hot jump/branch flags plus register-file read data to select the next PC.
- Produces the link value written to $r31 on JAL.

---
 rtl/pc_pkg.sv | 21 ++
 rtl/next_pc_sel.sv | 67 ++++++
 rtl/pc_fetch_unit.sv | 104 ++++++++++
 tb/tb_pc_fetch_unit.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and defaults for the PC / next-PC fetch stage.
// Imported by next_pc_sel and pc_fetch_unit.
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    STALL
  } fsm_state_e;

  typedef enum logic [1:0] {
    SRC_SEQ,
    SRC_BR,
    SRC_JMP,
    SRC_JR
  } pc_src_e;

  localparam int          PC_WIDTH_DEF = 12;
  localparam int unsigned RESET_PC_DEF = 0;

endpackage

// File: rtl/next_pc_sel.sv
// Combinational next-PC priority mux with branch/sequential adders.
// Illegal multi-flag combinations resolve JR > J/JAL > BEX > BNE > BLT.
module next_pc_sel
  import pc_pkg::*;
#(
  parameter int PC_WIDTH = PC_WIDTH_DEF
) (
  input  logic [PC_WIDTH-1:0] pc,
  input  logic                J,
  input  logic                JAL,
  input  logic                BEX,
  input  logic                BNE,
  input  logic                BLT,
  input  logic                JR,
  input  logic [16:0]         imm_n,
  input  logic [26:0]         target_t,
  input  logic [31:0]         data_rd,
  input  logic [31:0]         data_rs,
  input  logic [31:0]         data_rstatus,
  output logic [PC_WIDTH-1:0] next_pc,
  output logic [PC_WIDTH-1:0] pc_plus1,
  output logic                taken
);

  pc_src_e             src;
  logic [31:0]         imm_ext;
  logic [PC_WIDTH-1:0] br_pc;
  logic                bex_hit;
  logic                bne_hit;
  logic                blt_hit;
  logic                unused_bits;

  assign imm_ext  = {{15{imm_n[16]}}, imm_n};
  assign pc_plus1 = pc + PC_WIDTH'(1);
  assign br_pc    = pc_plus1 + imm_ext[PC_WIDTH-1:0];

  assign bex_hit = BEX && (data_rstatus != 32'd0);
  assign bne_hit = BNE && (data_rd != data_rs);
  assign blt_hit = BLT && ($signed(data_rd) < $signed(data_rs));

  // Sums wrap modulo 2^PC_WIDTH; high operand bits are dropped.
  assign unused_bits = ^{imm_ext[31:PC_WIDTH],
                         target_t[26:PC_WIDTH]};

  always_comb begin
    src = SRC_SEQ;
    priority case (1'b1)
      JR:               src = SRC_JR;
      J, JAL, bex_hit:  src = SRC_JMP;
      bne_hit, blt_hit: src = SRC_BR;
      default:          src = SRC_SEQ;
    endcase
  end

  always_comb begin
    next_pc = pc_plus1;
    unique case (src)
      SRC_JR:  next_pc = data_rd[PC_WIDTH-1:0];
      SRC_JMP: next_pc = target_t[PC_WIDTH-1:0];
      SRC_BR:  next_pc = br_pc;
      default: next_pc = pc_plus1;
    endcase
  end

  assign taken = (src != SRC_SEQ);

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and BOOT/RUN/STALL sequencing for the fetch stage.
// Optional self-jump halt detection under `define PC_HALT_DETECT_EN.
module pc_fetch_unit
  import pc_pkg::*;
#(
  parameter int          PC_WIDTH = PC_WIDTH_DEF,
  parameter int unsigned RESET_PC = RESET_PC_DEF
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                stall,
  input  logic                J,
  input  logic                JAL,
  input  logic                BEX,
  input  logic                BNE,
  input  logic                BLT,
  input  logic                JR,
  input  logic [16:0]         imm_n,
  input  logic [26:0]         target_t,
  input  logic [31:0]         data_rd,
  input  logic [31:0]         data_rs,
  input  logic [31:0]         data_rstatus,
  output logic [PC_WIDTH-1:0] pc_out,
  output logic [31:0]         link_pc,
  output logic                instr_valid,
  output logic                taken
`ifdef PC_HALT_DETECT_EN
  ,
  output logic                halted
`endif
);

  fsm_state_e          state_q;
  fsm_state_e          state_d;
  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] next_pc;
  logic [PC_WIDTH-1:0] pc_plus1;
  logic                sel_taken;
  logic                pc_en;
  logic                halt_q;

  next_pc_sel #(
    .PC_WIDTH(PC_WIDTH)
  ) u_sel (
    .pc          (pc_q),
    .J           (J),
    .JAL         (JAL),
    .BEX         (BEX),
    .BNE         (BNE),
    .BLT         (BLT),
    .JR          (JR),
    .imm_n       (imm_n),
    .target_t    (target_t),
    .data_rd     (data_rd),
    .data_rs     (data_rs),
    .data_rstatus(data_rstatus),
    .next_pc     (next_pc),
    .pc_plus1    (pc_plus1),
    .taken       (sel_taken)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) state_q <= BOOT;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT:    state_d = stall ? STALL : RUN;
      RUN:     if (stall) state_d = STALL;
      STALL:   if (!stall) state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    instr_valid = (state_q == RUN) && !halt_q;
    pc_en       = instr_valid && !stall;
    taken       = pc_en && sel_taken;
  end

  always_ff @(posedge clock) begin
    if (!reset_n)   pc_q <= PC_WIDTH'(RESET_PC);
    else if (pc_en) pc_q <= next_pc;
  end

`ifdef PC_HALT_DETECT_EN
  // A J that resolves to its own address parks the stage until reset.
  always_ff @(posedge clock) begin
    if (!reset_n)
      halt_q <= 1'b0;
    else if (pc_en && J && !JR && (next_pc == pc_q))
      halt_q <= 1'b1;
  end
  assign halted = halt_q;
`else
  assign halt_q = 1'b0;
`endif

  assign pc_out  = pc_q;
  assign link_pc = 32'(pc_plus1);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed plan plus random run
// against a cycle-level reference model of the next-PC rules.
module tb_pc_fetch_unit;

  localparam int W    = 12;
  localparam int MASK = (1 << W) - 1;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          stall;
  logic          J, JAL, BEX, BNE, BLT, JR;
  logic [16:0]   imm_n;
  logic [26:0]   target_t;
  logic [31:0]   data_rd, data_rs, data_rstatus;
  logic [W-1:0]  pc_out;
  logic [31:0]   link_pc;
  logic          instr_valid;
  logic          taken;
`ifdef PC_HALT_DETECT_EN
  logic          halted;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  int m_pc;
  bit m_valid;
  bit m_halt;

  always #5 clock = ~clock;

  pc_fetch_unit #(
    .PC_WIDTH(W),
    .RESET_PC(0)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .stall       (stall),
    .J           (J),
    .JAL         (JAL),
    .BEX         (BEX),
    .BNE         (BNE),
    .BLT         (BLT),
    .JR          (JR),
    .imm_n       (imm_n),
    .target_t    (target_t),
    .data_rd     (data_rd),
    .data_rs     (data_rs),
    .data_rstatus(data_rstatus),
    .pc_out      (pc_out),
    .link_pc     (link_pc),
    .instr_valid (instr_valid),
    .taken       (taken)
`ifdef PC_HALT_DETECT_EN
    ,
    .halted      (halted)
`endif
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Next PC straight from the priority rules, in integer arithmetic.
  function automatic int ref_next(output bit tk);
    logic signed [16:0] s;
    int off;
    s   = imm_n;
    off = s;
    tk  = 1'b1;
    if (JR)                                   return int'(data_rd) & MASK;
    if (J || JAL)                             return int'(target_t) & MASK;
    if (BEX && data_rstatus != 0)             return int'(target_t) & MASK;
    if (BNE && data_rd != data_rs)            return (m_pc + 1 + off) & MASK;
    if (BLT && $signed(data_rd) < $signed(data_rs))
                                              return (m_pc + 1 + off) & MASK;
    tk = 1'b0;
    return (m_pc + 1) & MASK;
  endfunction

  task automatic set_in(input logic        s,
                        input logic [5:0]  fl,
                        input logic [16:0] imm,
                        input logic [26:0] t,
                        input logic [31:0] rd,
                        input logic [31:0] rs,
                        input logic [31:0] rst);
    reset_n = 1'b1;
    stall   = s;
    {J, JAL, BEX, BNE, BLT, JR} = fl;
    imm_n        = imm;
    target_t     = t;
    data_rd      = rd;
    data_rs      = rs;
    data_rstatus = rst;
  endtask

  task automatic clear_in();
    set_in(1'b0, 6'b0, 17'd0, 27'd0, 32'd0, 32'd0, 32'd0);
  endtask

  // Checks outputs mid-cycle, then advances the model over one edge.
  task automatic cycle(input string tag);
    bit tk;
    int nx;
    @(negedge clock);
    nx = ref_next(tk);
    check({tag, "/pc"}, 64'(pc_out), 64'(m_pc));
    check({tag, "/valid"}, 64'(instr_valid), 64'(m_valid));
    check({tag, "/taken"}, 64'(taken), 64'(m_valid && !stall && tk));
    if (m_valid)
      check({tag, "/link"}, 64'(link_pc), 64'((m_pc + 1) & MASK));
`ifdef PC_HALT_DETECT_EN
    check({tag, "/halted"}, 64'(halted), 64'(m_halt));
`endif
    if (!reset_n) begin
      m_pc    = 0;
      m_valid = 1'b0;
      m_halt  = 1'b0;
    end else begin
      if (m_valid && !stall) begin
`ifdef PC_HALT_DETECT_EN
        if (J && !JR && nx == m_pc) m_halt = 1'b1;
`endif
        m_pc = nx;
      end
      m_valid = !stall && !m_halt;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic jump_to(input int a);
    int tries = 0;
    set_in(1'b0, 6'b000001, 17'd0, 27'd0, 32'(a), 32'd0, 32'd0);
    while (!(m_valid && m_pc == a) && tries < 6) begin
      cycle("jr_set");
      tries++;
    end
    check("jump_to", 64'(pc_out), 64'(a));
    clear_in();
  endtask

  initial begin
    logic [5:0] fl;
    int k;

    clear_in();
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    m_pc = 0; m_valid = 1'b0; m_halt = 1'b0;

    // Reset and boot
    reset_n = 1'b0;
    repeat (2) cycle("rst");
    reset_n = 1'b1;
    cycle("boot");
    check("boot_valid", 64'(instr_valid), 64'd1);
    check("boot_pc", 64'(pc_out), 64'd0);
    repeat (3) cycle("seq");
    check("seq_pc3", 64'(pc_out), 64'd3);

    // Branches at PC=10, N=-3
    jump_to(10);
    set_in(1'b0, 6'b000100, 17'(-3), 27'd0, 32'd5, 32'd5, 32'd0);
    cycle("bne_nt");
    check("bne_nt_pc", 64'(pc_out), 64'd11);
    jump_to(10);
    set_in(1'b0, 6'b000100, 17'(-3), 27'd0, 32'd5, 32'd6, 32'd0);
    cycle("bne_t");
    check("bne_t_pc", 64'(pc_out), 64'd8);
    jump_to(10);
    set_in(1'b0, 6'b000010, 17'(-3), 27'd0, 32'hFFFF_FFFF, 32'd1, 32'd0);
    #3;
    check("blt_taken", 64'(taken), 64'd1);
    cycle("blt");
    check("blt_pc", 64'(pc_out), 64'd8);

    // Jumps
    jump_to(20);
    set_in(1'b0, 6'b010000, 17'd0, 27'h7FF_0100, 32'd0, 32'd0, 32'd0);
    check("jal_link", 64'(link_pc), 64'd21);
    cycle("jal");
    check("jal_pc", 64'(pc_out), 64'h100);
    set_in(1'b0, 6'b000001, 17'd0, 27'd0, 32'hFFFF_0040, 32'd0, 32'd0);
    cycle("jr");
    check("jr_pc", 64'(pc_out), 64'h040);
    jump_to(20);
    set_in(1'b0, 6'b001000, 17'd0, 27'h123, 32'd0, 32'd0, 32'd0);
    cycle("bex_nt");
    check("bex_nt_pc", 64'(pc_out), 64'd21);
    jump_to(20);
    set_in(1'b0, 6'b001000, 17'd0, 27'h123, 32'd0, 32'd0, 32'd7);
    cycle("bex_t");
    check("bex_t_pc", 64'(pc_out), 64'h123);

    // Stall holding a taken BNE
    jump_to(5);
    set_in(1'b1, 6'b000100, 17'd4, 27'd0, 32'd1, 32'd2, 32'd0);
    repeat (4) cycle("stall");
    check("stall_pc", 64'(pc_out), 64'd5);
    stall = 1'b0;
    cycle("unstall");
    cycle("br_resolve");
    check("stall_br_pc", 64'(pc_out), 64'd10);
    clear_in();
    cycle("after_br");
    check("stall_once_pc", 64'(pc_out), 64'd11);

    // Wrap
    jump_to(MASK);
    cycle("wrap_seq");
    check("wrap_seq_pc", 64'(pc_out), 64'd0);
    set_in(1'b0, 6'b000100, 17'(-2), 27'd0, 32'd1, 32'd2, 32'd0);
    cycle("wrap_br");
    check("wrap_br_pc", 64'(pc_out), 64'hFFF);

    // Reset mid-stall
    jump_to(9);
    set_in(1'b1, 6'b000100, 17'd3, 27'd0, 32'd1, 32'd2, 32'd0);
    cycle("pre_rst");
    reset_n = 1'b0;
    cycle("rst_stall");
    check("rst_stall_pc", 64'(pc_out), 64'd0);
    check("rst_stall_valid", 64'(instr_valid), 64'd0);
    clear_in();
    cycle("reboot");

`ifdef PC_HALT_DETECT_EN
    jump_to(30);
    set_in(1'b0, 6'b100000, 17'd0, 27'd30, 32'd0, 32'd0, 32'd0);
    cycle("self_j");
    check("halt_set", 64'(halted), 64'd1);
    for (int i = 0; i < 6; i++) begin
      stall = i[0];
      cycle("halt_hold");
    end
    check("halt_pc", 64'(pc_out), 64'd30);
    reset_n = 1'b0;
    cycle("halt_rst");
    clear_in();
`endif

    // Randomized run
    for (int i = 0; i < 600; i++) begin
      reset_n = ($urandom_range(0, 59) != 0);
      stall   = ($urandom_range(0, 4) == 0);
      fl = 6'b0;
      k  = $urandom_range(0, 7);
      if (k < 6) fl[k] = 1'b1;
      if ($urandom_range(0, 9) == 0) fl[$urandom_range(0, 5)] = 1'b1;
      {J, JAL, BEX, BNE, BLT, JR} = fl;
      imm_n        = 17'($urandom);
      target_t     = 27'($urandom);
      data_rs      = $urandom;
      data_rd      = ($urandom_range(0, 2) == 0) ? data_rs : $urandom;
      data_rstatus = ($urandom_range(0, 1) == 0) ? 32'd0 : $urandom;
      cycle("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
